nv_nvdla_sdp_rd_arb: RTL
========================

NV_NVDLA_SDP_RD_ARB -- requirements
Module: nv_nvdla_sdp_rd_arb

Interface
REQ-001 Parameter ORD_DEPTH, default 8: order-FIFO depth, i.e. max outstanding read requests; power of 2, at least 2.
REQ-002 Port nvdla_core_clk, input, 1: single clock; all logic on its rising edge.
REQ-003 Port nvdla_core_rst, input, 1: reset, asynchronous and active-high.
REQ-004 Port req_valid, input, 4: per-requester read-request valid; index 0=sdp, 1=sdp_b, 2=sdp_n, 3=sdp_e.
REQ-005 Port req_ready, output, 4: per-requester accept.
REQ-006 Port req_pd, input, 4x79: per-requester request; [63:0] address, [78:64] size (beats minus 1).
REQ-007 Port dma_rd_req_valid / dma_rd_req_ready / dma_rd_req_pd, output / input / output (79 bits): shared memory read-request port.
REQ-008 Port dma_rd_rsp_valid / dma_rd_rsp_ready / dma_rd_rsp_pd, input / output / input (257 bits): shared read-response port; [255:0] data, [256] mask.
REQ-009 Port rsp_valid, output, 4; rsp_ready, input, 4; rsp_pd, output, 257: per-requester responses, with rsp_pd common to all requesters.
REQ-010 Port busy, output, 1: high while any request is outstanding or the output register is full.
REQ-011 Port rsp_orphan, output, 1: sticky flag; a response arrived with no outstanding request.

Function
REQ-012 Round-robin arbitration SHALL run over the asserted req_valid bits, searching upward from priority pointer ptr with wrap 3->0.
REQ-013 Accept condition: acc = (!dma_rd_req_valid | dma_rd_req_ready) & !ord_full.
- req_ready[i] = grant[i] & acc.
- req_ready is combinational; it has no dependency on the req_ready outputs.
REQ-014 On a request accept:
- the granted pd SHALL be loaded into the output register;
- dma_rd_req_valid SHALL assert the next cycle (latency 1);
- ptr SHALL be set to (granted index + 1) mod 4.
REQ-015 When no request is accepted, ptr SHALL hold.
REQ-016 While dma_rd_req_valid=1 and dma_rd_req_ready=0, dma_rd_req_pd SHALL stay stable.
REQ-017 Back-to-back accepts SHALL be sustained at 1 per cycle when dma_rd_req_ready=1.
REQ-018 Each request accept SHALL push {id[1:0], size[14:0]} into the order FIFO.
REQ-019 When the order FIFO is full, acc=0, even if a pop occurs in the same cycle.
REQ-020 Response routing: rsp_valid[i] = dma_rd_rsp_valid & !ord_empty & (head.id==i); dma_rd_rsp_ready = !ord_empty & rsp_ready[head.id]; rsp_pd = dma_rd_rsp_pd.
REQ-021 Beat counter (16 bits) SHALL increment on each response handshake.
- When the counter equals head.size at a handshake, the FIFO SHALL pop and the counter SHALL return to 0.
- size=0 means one beat.
- size=0x7FFF means 32768 beats, with no counter overflow.
REQ-022 A push and a pop in the same cycle (FIFO not full) SHALL leave the occupancy unchanged.
REQ-023 dma_rd_rsp_valid=1 with ord_empty=1 SHALL set rsp_orphan.
- dma_rd_rsp_ready stays 0 in that case.
- rsp_orphan clears only on reset.
REQ-024 busy = !ord_empty | dma_rd_req_valid.

Reset
REQ-025 While nvdla_core_rst=1, the following SHALL be 0: dma_rd_req_valid, dma_rd_req_pd, req_ready, rsp_valid, dma_rd_rsp_ready, busy, rsp_orphan, ptr, the beat counter and the FIFO pointers.
REQ-026 Reset asserted mid-operation SHALL drop all outstanding state immediately, with no completion of partial bursts.
REQ-027 Operation resumes on the first clock edge after deassertion.

Structure
REQ-028 The shared package nv_nvdla_sdp_rd_arb_pkg SHALL hold:
- constants N_REQ=4, ADDR_W=64, SIZE_W=15, REQ_PD_W=79, RSP_PD_W=257, ID_W=2;
- typedef ord_entry_t = {id, size}.
REQ-029 The order FIFO SHALL be the single sub-module nv_nvdla_sdp_rd_ord_fifo: depth ORD_DEPTH, flop-based, with full and empty outputs.

Verification
REQ-030 All four req_valid held high with dma_rd_req_ready=1, size=0 each -> grants issue in order 0,1,2,3,0, one per cycle; each pd appears on the output 1 cycle after its accept.
REQ-031 Requester 2, size=3; dma_rd_req_ready held 0 for 5 cycles -> output pd stable and req_ready=0 throughout; 4 response beats appear on rsp_valid[2] only; busy deasserts after the 4th beat.
REQ-032 ORD_DEPTH=8, 9 requests issued with responses withheld -> 8 accepted; 9th req_ready=0 until the first response burst completes; it is accepted in the cycle after that pop.
REQ-033 Requests from 1 (size=1) then 3 (size=0); rsp_ready[1] low for 2 cycles -> dma_rd_rsp_ready=0 while it is low; beats route 1,1,3; rsp_valid[3] is never high during requester 1's beats.
REQ-034 dma_rd_rsp_valid pulsed with no outstanding request -> rsp_orphan=1 next cycle and stays 1 until reset; dma_rd_rsp_ready=0.
REQ-035 Reset asserted in the middle of a 4-beat burst -> all outputs 0 in the same cycle without a clock edge; after release, a new request from requester 0 is granted first, with ptr back at 0.

Source files
------------

// File: rtl/nv_nvdla_sdp_rd_arb_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// nv_nvdla_sdp_rd_arb_pkg
// Shared definitions for the SDP read arbiter: requester count, payload
// widths, the order-FIFO entry layout and the round-robin helpers used by
// the arbiter top level.
// ---------------------------------------------------------------------------
package nv_nvdla_sdp_rd_arb_pkg;

  localparam int N_REQ    = 4;
  localparam int ADDR_W   = 64;
  localparam int SIZE_W   = 15;
  localparam int REQ_PD_W = 79;
  localparam int RSP_PD_W = 257;
  localparam int ID_W     = 2;
  localparam int BEAT_W   = 16;

  // One order-FIFO entry: which requester issued the read and how many
  // beats (minus one) it expects back.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [SIZE_W-1:0] size;
  } ord_entry_t;

  // Round-robin pick: the first asserted valid bit found when walking
  // upward from ptr, wrapping from the top requester back to 0.
  function automatic logic [N_REQ-1:0] rr_grant(
    input logic [N_REQ-1:0] valid,
    input logic [ID_W-1:0]  ptr
  );
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  idx;
    logic             found;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + ID_W'(k);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

  // Encode a one-hot grant into a requester index (0 when nothing granted).
  function automatic logic [ID_W-1:0] onehot_to_idx(
    input logic [N_REQ-1:0] oh
  );
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (oh[k]) begin
        idx = ID_W'(k);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/nv_nvdla_sdp_rd_ord_fifo.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// nv_nvdla_sdp_rd_ord_fifo
// Flop-based order FIFO remembering, for every outstanding read request, the
// issuing requester and its burst length. The head entry steers responses.
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   i_push        - write i_push_data (ignored while full)
//   i_push_data   - entry to enqueue
//   i_pop         - drop the head entry (ignored while empty)
//   o_head        - current head entry
//   o_full        - DEPTH entries held
//   o_empty       - no entries held
// ---------------------------------------------------------------------------
module nv_nvdla_sdp_rd_ord_fifo
  import nv_nvdla_sdp_rd_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  ord_entry_t i_push_data,
  input  logic       i_pop,
  output ord_entry_t o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  ord_entry_t  r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  // Pointers carry one extra wrap bit so that full and empty are told apart
  // by comparing the wrap bits when the index bits match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; a simultaneous push and pop moves both pointers so the
  // occupancy is unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage needs no reset: an entry is only ever read after being written,
  // because the pointers are what reset clears.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end
  end

endmodule

// File: rtl/nv_nvdla_sdp_rd_arb.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// nv_nvdla_sdp_rd_arb
// Four-way round-robin read-request arbiter for SDP with response routing.
// Requests from sdp / sdp_b / sdp_n / sdp_e share one memory read port; the
// accepted payload sits in a single output register. The order FIFO records
// who asked for how many beats so that returning data is steered back to the
// right requester in issue order.
//
// Ports:
//   nvdla_core_clk, nvdla_core_rst        - clock, async active-high reset
//   req_valid/req_ready/req_pd            - per-requester read requests
//   dma_rd_req_valid/_ready/_pd           - shared memory read-request port
//   dma_rd_rsp_valid/_ready/_pd           - shared memory read-response port
//   rsp_valid/rsp_ready, rsp_pd           - per-requester responses (common pd)
//   busy                                  - requests outstanding or pending
//   rsp_orphan                            - sticky: response with nothing owed
// ---------------------------------------------------------------------------
module nv_nvdla_sdp_rd_arb
  import nv_nvdla_sdp_rd_arb_pkg::*;
#(
  parameter int ORD_DEPTH = 8
) (
  input  logic                           nvdla_core_clk,
  input  logic                           nvdla_core_rst,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ-1:0][REQ_PD_W-1:0] req_pd,
  output logic                           dma_rd_req_valid,
  input  logic                           dma_rd_req_ready,
  output logic [REQ_PD_W-1:0]            dma_rd_req_pd,
  input  logic                           dma_rd_rsp_valid,
  output logic                           dma_rd_rsp_ready,
  input  logic [RSP_PD_W-1:0]            dma_rd_rsp_pd,
  output logic [N_REQ-1:0]               rsp_valid,
  input  logic [N_REQ-1:0]               rsp_ready,
  output logic [RSP_PD_W-1:0]            rsp_pd,
  output logic                           busy,
  output logic                           rsp_orphan
);

  logic [ID_W-1:0]     r_ptr;
  logic                r_req_valid;
  logic [REQ_PD_W-1:0] r_req_pd;
  logic [BEAT_W-1:0]   r_beat_cnt;
  logic                r_orphan;

  logic [N_REQ-1:0]    w_grant;
  logic [ID_W-1:0]     w_grant_idx;
  logic                w_acc;
  logic                w_accept;
  ord_entry_t          w_push_data;
  ord_entry_t          w_head;
  logic                w_ord_full;
  logic                w_ord_empty;
  logic                w_rsp_hs;
  logic                w_last_beat;
  logic                w_pop;

  // Request side. The output register can take a new request when it is
  // empty or draining this cycle; a full order FIFO blocks acceptance even
  // if it pops in the same cycle. req_ready is forced low during reset since
  // acc alone would otherwise read as true while the flops are cleared.
  assign w_grant     = rr_grant(req_valid, r_ptr);
  assign w_grant_idx = onehot_to_idx(w_grant);
  assign w_acc       = (!r_req_valid || dma_rd_req_ready) && !w_ord_full;
  assign req_ready   = (nvdla_core_rst || !w_acc) ? '0 : w_grant;
  assign w_accept    = |req_ready;

  assign w_push_data.id   = w_grant_idx;
  assign w_push_data.size = req_pd[w_grant_idx][REQ_PD_W-1:ADDR_W];

  assign dma_rd_req_valid = r_req_valid;
  assign dma_rd_req_pd    = r_req_pd;

  // Output register: loads the granted payload on accept, otherwise holds
  // its payload (stable under backpressure) and empties once taken.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_req_valid <= 1'b0;
      r_req_pd    <= '0;
    end else if (w_accept) begin
      r_req_valid <= 1'b1;
      r_req_pd    <= req_pd[w_grant_idx];
    end else if (dma_rd_req_ready) begin
      r_req_valid <= 1'b0;
    end
  end

  // Priority pointer moves just past the winner on every accept and holds
  // otherwise, so each requester gets its turn.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= w_grant_idx + 2'd1;
    end
  end

  nv_nvdla_sdp_rd_ord_fifo #(
    .DEPTH (ORD_DEPTH)
  ) u_ord_fifo (
    .clk         (nvdla_core_clk),
    .rst         (nvdla_core_rst),
    .i_push      (w_accept),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_ord_full),
    .o_empty     (w_ord_empty)
  );

  // Response side: the FIFO head owns the response stream. Nothing is
  // steered or accepted while no request is outstanding.
  assign rsp_valid        = (dma_rd_rsp_valid && !w_ord_empty) ?
                            ({{(N_REQ-1){1'b0}}, 1'b1} << w_head.id) : '0;
  assign dma_rd_rsp_ready = !w_ord_empty && rsp_ready[w_head.id];
  assign rsp_pd           = dma_rd_rsp_pd;

  assign w_rsp_hs    = dma_rd_rsp_valid && dma_rd_rsp_ready;
  assign w_last_beat = (r_beat_cnt == {1'b0, w_head.size});
  assign w_pop       = w_rsp_hs && w_last_beat;

  // Beat counter is one bit wider than size, so a 32768-beat burst reaches
  // its last beat (0x7FFF) without wrapping.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_beat_cnt <= '0;
    end else if (w_rsp_hs) begin
      if (w_last_beat) begin
        r_beat_cnt <= '0;
      end else begin
        r_beat_cnt <= r_beat_cnt + 16'd1;
      end
    end
  end

  // Sticky orphan flag: data showed up with no request owed. Only reset
  // clears it.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_orphan <= 1'b0;
    end else if (dma_rd_rsp_valid && w_ord_empty) begin
      r_orphan <= 1'b1;
    end
  end

  assign rsp_orphan = r_orphan;
  assign busy       = !w_ord_empty || r_req_valid;

endmodule
